spislave: RTL and testbench
===========================

# spislave

SPI responder: the target-side counterpart of the `spimaster` block. It samples an external master's clock, chip-select and MOSI lines, which arrive from the IO buffers, inside the system clock domain. It deserialises MOSI into words and serialises a host-loaded word onto MISO. It sits between the IO buffer/SB_IO layer and the memory-controller FIFOs, and is used when the Bus Pirate acts as a slave or snoops a bus.

## Interface
Parameters:
- `WIDTH`, 8: bits per transfer, MSB first.
- `SYNC_STAGES`, 2: flip-flop stages on each external input (≥2).
- `IDLE_WORD`, all ones: word shifted out when no transmit word is loaded.

Ports:
- `clock` input 1: system clock; the only clock.
- `reset` input 1: synchronous, active-low; every register is initialised on the `clock` edge where `reset`=0.
- `cpol`, `cpha` input 1 each: SPI mode. Static while CS is active.
- `cspol` input 1: 1 means CS is active-low (matches `spimaster`).
- `spi_clock`, `spi_cs`, `spi_mosi` input 1 each: raw pin inputs, asynchronous.
- `spi_miso` output 1: serial data out.
- `spi_miso_oe` output 1: drives the iobuf `oe`; high only while CS is active.
- `tx_data` input WIDTH: next word to transmit.
- `tx_load` input 1: one-cycle strobe that captures `tx_data` into the transmit buffer.
- `tx_empty` output 1: transmit buffer is free.
- `rx_data` output WIDTH: last received word; held until the next word completes.
- `rx_valid` output 1: one-cycle strobe with a new `rx_data`; wires to FIFO `in_shift`.
- `underrun` output 1: sticky; a word started with an empty transmit buffer.
- `flag_clear` input 1: clears `underrun`.
- `busy` output 1: CS active (synchronised).

## Operation
- **Synchronisation.** `spi_clock`, `spi_cs` and `spi_mosi` each pass through SYNC_STAGES flip-flops. Edges are detected by comparing the last synchronised stage with a delay register. `cs_act` = synchronised `spi_cs` XOR `cspol`, inverted so that 1 means active.
- **Edge roles.**
  - When `cpol`==`cpha`, the sample edge is rising and the shift edge is falling.
  - Otherwise, the sample edge is falling and the shift edge is rising.
- **States.**
  - IDLE → ACTIVE on the `cs_act` rise.
  - ACTIVE → IDLE on the `cs_act` fall.
- **On entering ACTIVE:**
  - Bit counter ← 0.
  - `load_pending` ← 1.
  - If `cpha`=0, perform a load immediately and clear `load_pending`.
- **Load.**
  - If the transmit buffer is full, shift register ← buffer and `tx_empty` ← 1.
  - Otherwise, shift register ← IDLE_WORD and `underrun` ← 1.
- **Shift edge in ACTIVE:**
  - If `load_pending`: load, then clear `load_pending`.
  - Else: shift register ← shift register << 1.
- `spi_miso` = shift register MSB.
- **Sample edge in ACTIVE:**
  - rx shift register ← {rx[WIDTH-2:0], synchronised MOSI}.
  - Counter increments.
  - When the counter reaches WIDTH-1, the word is complete:
    - `rx_data` ← the assembled word.
    - `rx_valid` pulses.
    - Counter ← 0.
    - `load_pending` ← 1.
- **CS deasserted mid-word.** The partial word is discarded with no `rx_valid`. The counter clears, `load_pending` clears, and an already-loaded transmit word is lost (not restored). `spi_miso_oe` falls.
- **`tx_load`.**
  - Accepted at any time; the buffer is overwritten if it is already full. The last write wins.
  - If `tx_load` and a load from the buffer occur in the same cycle, the load takes the old buffer contents. The new word is then stored and `tx_empty` ends at 0.
- **Edge events in IDLE** are ignored.
- **`flag_clear` and `underrun` set in the same cycle:** set wins.

## Timing
- **Reset values:**
  - `spi_miso`=1 (the shift register resets to IDLE_WORD).
  - `spi_miso_oe`=0, `busy`=0, `tx_empty`=1, `rx_valid`=0, `underrun`=0.
  - `rx_data`=0.
  - State IDLE.
  - Sync registers: 0 if `cpol`=0, else 1 (no false edge after reset).
- **Latency:**
  - A pin edge reaches the detect logic after SYNC_STAGES+1 clocks.
  - `rx_valid` asserts in the cycle after that.
  - `spi_miso` changes SYNC_STAGES+2 clocks after the pin shift edge.
- **Maximum SCK:** `clock`/8. Each SCK half-period must be at least 4 clocks so that MISO settles before the master samples.
- **CS setup:** CS assertion must precede the first SCK edge by at least 4 clocks.
- `rx_valid` is exactly 1 cycle wide. Back-to-back words produce strobes at least 2·WIDTH·4 clocks apart.
- **Reset mid-transfer:** immediate return to the reset values. The transfer resumes only on the next CS assertion.

## Test plan
- **Mode 0, single word.** `cspol`=1; load 0xA5; master sends 0x3C at `clock`/8. Required: MISO carries 0xA5; one `rx_valid` with `rx_data`=0x3C; `tx_empty`=1 after the first bit.
- **All four modes.** Two back-to-back words; tx 0x81 then 0x7E, rx 0xF0 then 0x0F. Required: both words correct in each mode and two `rx_valid` pulses.
- **Underrun.** No `tx_load`; master clocks one word. Required: MISO = 0xFF, `underrun`=1. After `flag_clear`, `underrun`=0.
- **CS abort.** CS deasserts after 5 bits. Required: no `rx_valid`, `spi_miso_oe`=0, and the next full word (0x55) is received correctly.
- **Reset mid-word.** `reset`=0 for 1 cycle after 3 bits. Required: all outputs at their reset values; the next CS assertion produces correct 0xC3 reception.
- **Load collision.** `tx_load` of 0x22 in the same cycle as the buffer load of 0x11. Required: MISO sends 0x11, the following word sends 0x22, and `tx_empty`=0 in between.

Source files
------------

// File: rtl/spislave.sv
// spislave: SPI target that oversamples SCK/CS/MOSI in the system clock domain,
// deserialises MOSI into words and shifts a host-loaded word out on MISO.
module spislave #(
  parameter int              WIDTH       = 8,
  parameter int              SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] IDLE_WORD  = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             cspol,
  input  logic             spi_clock,
  input  logic             spi_cs,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_empty,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             underrun,
  input  logic             flag_clear,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic r_sck_d, r_cs_d, r_load_pending, r_tx_empty, r_rx_valid, r_underrun;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_sr, r_buf, r_rx_data;
  logic [WIDTH-2:0] r_rx;
  logic w_sck, w_cs_act, w_mosi, w_rise, w_fall, w_sample, w_shift;
  logic w_cs_rise, w_cs_fall, w_enter, w_exit, w_run, w_load;
  logic [WIDTH-1:0] w_rx_next;
  assign w_sck     = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_act  = r_cs_sync[SYNC_STAGES-1] ^ cspol;
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sck & ~r_sck_d;
  assign w_fall    = ~w_sck & r_sck_d;
  assign w_sample  = (cpol == cpha) ? w_rise : w_fall;
  assign w_shift   = (cpol == cpha) ? w_fall : w_rise;
  assign w_cs_rise = w_cs_act & ~r_cs_d;
  assign w_cs_fall = ~w_cs_act & r_cs_d;
  assign w_enter   = (r_state == IDLE) && w_cs_rise;
  assign w_exit    = (r_state == ACTIVE) && w_cs_fall;
  assign w_run     = (r_state == ACTIVE) && !w_cs_fall;
  assign w_load    = (w_enter && !cpha) || (w_run && w_shift && r_load_pending);
  assign w_rx_next = {r_rx, w_mosi};
  always_comb w_next = w_enter ? ACTIVE : w_exit ? IDLE : r_state;
  always_ff @(posedge clock)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sck_sync     <= {SYNC_STAGES{cpol}};
      r_mosi_sync    <= {SYNC_STAGES{cpol}};
      r_sck_d        <= cpol;
      // CS comes out of reset looking already active, so a CS held low
      // through reset never fakes an assertion; only a fresh one starts a word
      r_cs_sync      <= {SYNC_STAGES{~cspol}};
      r_cs_d         <= 1'b1;
      r_load_pending <= 1'b0;
      r_tx_empty     <= 1'b1;
      r_rx_valid     <= 1'b0;
      r_underrun     <= 1'b0;
      r_cnt          <= '0;
      r_sr           <= IDLE_WORD;
      r_buf          <= '0;
      r_rx_data      <= '0;
      r_rx           <= '0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_clock};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs_act;
      r_rx_valid  <= 1'b0;
      if (flag_clear) r_underrun <= 1'b0;
      if (w_load) begin
        if (!r_tx_empty) begin
          r_sr       <= r_buf;
          r_tx_empty <= 1'b1;
        end else begin
          r_sr       <= IDLE_WORD;
          r_underrun <= 1'b1;
        end
      end else if (w_run && w_shift) r_sr <= r_sr << 1;
      // a same-cycle host write lands after the load has taken the old word
      if (tx_load) begin
        r_buf      <= tx_data;
        r_tx_empty <= 1'b0;
      end
      if (w_enter) begin
        r_cnt          <= '0;
        r_load_pending <= cpha;
      end else if (w_exit) begin
        r_cnt          <= '0;
        r_load_pending <= 1'b0;
      end else if (w_run) begin
        if (w_shift) r_load_pending <= 1'b0;
        if (w_sample) begin
          r_rx <= w_rx_next[WIDTH-2:0];
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_rx_data      <= w_rx_next;
            r_rx_valid     <= 1'b1;
            r_cnt          <= '0;
            r_load_pending <= 1'b1;
          end else r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end
  assign spi_miso    = r_sr[WIDTH-1];
  assign spi_miso_oe = (r_state == ACTIVE);
  assign busy        = (r_state == ACTIVE);
  assign tx_empty    = r_tx_empty;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign underrun    = r_underrun;
endmodule

// File: tb/tb_spislave.sv
// tb_spislave: directed SPI master stimulus; received words checked by a
// queue-based monitor, MISO words and flags checked inline.
module tb_spislave;
  localparam int H = 4;
  logic clock = 1'b0, reset = 1'b0;
  logic cpol = 1'b0, cpha = 1'b0, cspol = 1'b1;
  logic sck = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic miso, miso_oe, tx_empty, rx_valid, underrun, busy;
  logic [7:0] tx_data = 8'h00, rx_data;
  logic tx_load = 1'b0, flag_clear = 1'b0;
  int checks = 0, errors = 0, n_rx = 0, n0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp, a, b;

  spislave #(.WIDTH(8), .SYNC_STAGES(2), .IDLE_WORD(8'hFF)) dut (
    .clock(clock), .reset(reset), .cpol(cpol), .cpha(cpha), .cspol(cspol),
    .spi_clock(sck), .spi_cs(cs), .spi_mosi(mosi), .spi_miso(miso),
    .spi_miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_empty(tx_empty), .rx_data(rx_data), .rx_valid(rx_valid),
    .underrun(underrun), .flag_clear(flag_clear), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (rx_valid) begin
      n_rx++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected actual %h required no strobe", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_data !== mon_exp) begin
          errors++;
          $display("FAIL rx_word actual %h required %h", rx_data, mon_exp);
        end
      end
    end

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %b required %b", name, act, req);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    @(negedge clock);
    tx_load = 1'b0;
  endtask

  task automatic clear_flag();
    flag_clear = 1'b1;
    @(negedge clock);
    flag_clear = 1'b0;
  endtask

  task automatic set_mode(input int m);
    cpol = m[1];
    cpha = m[0];
    sck  = m[1];
    wait_clk(8);
  endtask

  task automatic cs_on();
    cs = 1'b0;
    wait_clk(8);
  endtask

  task automatic cs_off();
    wait_clk(H);
    cs = 1'b1;
    wait_clk(8);
  endtask

  // one word (or its first nbits) as an SPI master; optional host load after bit ld_bit
  task automatic xfer(input logic [7:0] mo, input int nbits, input int ld_bit,
                      input logic [7:0] ld_val, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (cpha) sck = ~cpol;
      mosi = mo[7-i];
      wait_clk(H);
      mi[7-i] = miso;
      sck = cpha ? cpol : ~cpol;
      wait_clk(H);
      if (!cpha) sck = cpol;
      if (i == ld_bit) load(ld_val);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(2);
    reset = 1'b1;
    chk1("rst_miso", miso, 1'b1);
    chk1("rst_oe", miso_oe, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_tx_empty", tx_empty, 1'b1);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_underrun", underrun, 1'b0);
    chk8("rst_rx_data", rx_data, 8'h00);
    wait_clk(4);

    // mode 0 single word
    load(8'hA5);
    chk1("m0_tx_full", tx_empty, 1'b0);
    exp_q.push_back(8'h3C);
    cs_on();
    chk1("m0_busy", busy, 1'b1);
    chk1("m0_oe", miso_oe, 1'b1);
    chk1("m0_tx_empty", tx_empty, 1'b1);
    xfer(8'h3C, 8, -1, 8'h00, a);
    cs_off();
    chk8("m0_miso", a, 8'hA5);
    chk8("m0_rx_data", rx_data, 8'h3C);
    chk1("m0_oe_off", miso_oe, 1'b0);

    // all four modes, two back-to-back words each
    for (int m = 0; m < 4; m++) begin
      set_mode(m);
      n0 = n_rx;
      load(8'h81);
      exp_q.push_back(8'hF0);
      exp_q.push_back(8'h0F);
      cs_on();
      xfer(8'hF0, 8, 0, 8'h7E, a);
      xfer(8'h0F, 8, -1, 8'h00, b);
      cs_off();
      chk8($sformatf("mode%0d_miso1", m), a, 8'h81);
      chk8($sformatf("mode%0d_miso2", m), b, 8'h7E);
      chk8($sformatf("mode%0d_rx_count", m), 8'(n_rx - n0), 8'd2);
    end

    // underrun
    set_mode(0);
    clear_flag();
    chk1("ur_cleared_before", underrun, 1'b0);
    exp_q.push_back(8'h96);
    cs_on();
    xfer(8'h96, 8, -1, 8'h00, a);
    cs_off();
    chk8("ur_miso", a, 8'hFF);
    chk1("ur_set", underrun, 1'b1);
    clear_flag();
    chk1("ur_clear", underrun, 1'b0);

    // CS abort after 5 bits
    n0 = n_rx;
    load(8'h33);
    cs_on();
    xfer(8'hAA, 5, -1, 8'h00, a);
    cs_off();
    chk8("abort_partial_miso", a, 8'h30);
    chk1("abort_oe", miso_oe, 1'b0);
    chk8("abort_no_rx", 8'(n_rx - n0), 8'd0);
    load(8'h66);
    exp_q.push_back(8'h55);
    cs_on();
    xfer(8'h55, 8, -1, 8'h00, a);
    cs_off();
    chk8("abort_next_miso", a, 8'h66);
    chk8("abort_next_rx_count", 8'(n_rx - n0), 8'd1);

    // reset mid-word
    cs_on();
    xfer(8'hE0, 3, 1, 8'h34, a);
    chk1("rw_pre_tx_full", tx_empty, 1'b0);
    chk1("rw_pre_underrun", underrun, 1'b1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk1("rw_miso", miso, 1'b1);
    chk1("rw_oe", miso_oe, 1'b0);
    chk1("rw_busy", busy, 1'b0);
    chk1("rw_tx_empty", tx_empty, 1'b1);
    chk1("rw_rx_valid", rx_valid, 1'b0);
    chk1("rw_underrun", underrun, 1'b0);
    chk8("rw_rx_data", rx_data, 8'h00);
    wait_clk(8);
    chk1("rw_no_resume", busy, 1'b0);
    cs = 1'b1;
    wait_clk(8);
    load(8'h5C);
    exp_q.push_back(8'hC3);
    cs_on();
    xfer(8'hC3, 8, -1, 8'h00, a);
    cs_off();
    chk8("rw_next_miso", a, 8'h5C);
    chk8("rw_next_rx_data", rx_data, 8'hC3);

    // tx_load colliding with the CS-entry buffer load
    load(8'h11);
    cs = 1'b0;
    wait_clk(2);
    tx_data = 8'h22;
    tx_load = 1'b1;
    @(negedge clock);
    tx_load = 1'b0;
    wait_clk(5);
    chk1("col_busy", busy, 1'b1);
    chk1("col_tx_full", tx_empty, 1'b0);
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'hB4);
    xfer(8'h4B, 8, -1, 8'h00, a);
    xfer(8'hB4, 8, -1, 8'h00, b);
    cs_off();
    chk8("col_miso1", a, 8'h11);
    chk8("col_miso2", b, 8'h22);
    chk1("col_tx_empty_end", tx_empty, 1'b1);

    wait_clk(4);
    chk8("rx_queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
